// File: rtl/pll_seq_pkg.sv
// Shared state encoding, default timing and helpers for the PLL reset sequencer
// and the blocks that sit beside it.
package pll_seq_pkg;

    localparam logic [2:0] S_HOLD   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STABLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;

    typedef enum logic [2:0] {
        ST_HOLD   = S_HOLD,
        ST_WAIT   = S_WAIT,
        ST_STABLE = S_STABLE,
        ST_RUN    = S_RUN,
        ST_FAIL   = S_FAIL
    } seq_state_e;

    localparam int DEF_RST_HOLD_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT    = 4096;
    localparam int DEF_LOCK_STABLE     = 64;
    localparam int DEF_MAX_RETRIES     = 3;
    localparam int DEF_CNT_WIDTH       = 16;

    // A zero-retry build still needs a one-bit counter to carry the value 0.
    function automatic int retry_width(input int max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// Control/status bundle between the PLL reset sequencer and whoever owns the PLL:
// the sequencer takes the slave side, the board/clocking logic the master side.
interface pll_reset_seq_if
    import pll_seq_pkg::*;
#(
    parameter int RW = retry_width(DEF_MAX_RETRIES)
);

    logic          pll_locked;
    logic          restart;
    logic          pll_rst;
    logic          ready;
    logic          fail;
    logic          lock_lost;
    logic [RW-1:0] retry_cnt;

    modport master (
        output pll_locked,
        output restart,
        input  pll_rst,
        input  ready,
        input  fail,
        input  lock_lost,
        input  retry_cnt
    );

    modport slave (
        input  pll_locked,
        input  restart,
        output pll_rst,
        output ready,
        output fail,
        output lock_lost,
        output retry_cnt
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchroniser, reset to 0; used for every slow level
// crossing into a local clock domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// Power-up / recovery sequencer for one PLL: timed reset hold, lock wait with
// timeout and bounded retries, lock-stability qualification, then ready.
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE     = DEF_LOCK_STABLE,
    parameter int MAX_RETRIES     = DEF_MAX_RETRIES,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
    localparam int RW             = retry_width(MAX_RETRIES)
) (
    input  logic           clk,
    input  logic           rst,
    pll_reset_seq_if.slave seq_io
);

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE - 1);
    localparam logic [RW-1:0]        RETRY_LAST   = RW'(MAX_RETRIES);

    seq_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic                 pll_rst_q, pll_rst_d;
    logic                 ready_q, ready_d;
    logic                 fail_q, fail_d;
    logic                 lock_lost_q, lock_lost_d;
    logic                 lk;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (seq_io.pll_locked),
        .q_o (lk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;

        // restart outranks every in-state event, including lock loss and timeout
        if (seq_io.restart) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (lk) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = '0;
                        if (retry_q == RETRY_LAST) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_HOLD;
                            retry_d = retry_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!lk) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // a lock drop after qualification starts a fresh sequence
                    if (!lk) begin
                        state_d     = ST_HOLD;
                        cnt_d       = '0;
                        retry_d     = '0;
                        lock_lost_d = 1'b1;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they switch on the transition edge.
        pll_rst_d = (state_d == ST_HOLD) || (state_d == ST_FAIL);
        ready_d   = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    assign seq_io.pll_rst   = pll_rst_q;
    assign seq_io.ready     = ready_q;
    assign seq_io.fail      = fail_q;
    assign seq_io.lock_lost = lock_lost_q;
    assign seq_io.retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: dut_a uses default timing, dut_b a short timeout,
// short stability window and two retries. Expected output changes are queued.
module tb_pll_reset_seq;
    import pll_seq_pkg::*;

    typedef struct packed {
        int         cyc;
        logic [5:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];
    logic [5:0] prev_a, prev_b;
    logic [5:0] vec_a, vec_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pll_reset_seq_if #(.RW(2)) ifa ();
    pll_reset_seq_if #(.RW(2)) ifb ();

    pll_reset_seq dut_a (
        .clk    (clk),
        .rst    (rst),
        .seq_io (ifa)
    );

    pll_reset_seq #(
        .RST_HOLD_CYCLES (16),
        .LOCK_TIMEOUT    (100),
        .LOCK_STABLE     (8),
        .MAX_RETRIES     (2),
        .CNT_WIDTH       (16)
    ) dut_b (
        .clk    (clk),
        .rst    (rst),
        .seq_io (ifb)
    );

    // observed output word: {retry_cnt, lock_lost, fail, ready, pll_rst}
    assign vec_a = {ifa.retry_cnt, ifa.lock_lost, ifa.fail, ifa.ready, ifa.pll_rst};
    assign vec_b = {ifb.retry_cnt, ifb.lock_lost, ifb.fail, ifb.ready, ifb.pll_rst};

    function automatic logic [5:0] mk(input int r, input bit ll, input bit f, input bit rdy, input bit pr);
        logic [1:0] rr;
        rr = r[1:0];
        return {rr, ll, f, rdy, pr};
    endfunction

    // Waits (bounded) for the next change of the selected DUT's outputs, sampled at negedge.
    task automatic next_event(input bit sel_b, input int budget, output int ev_cyc,
                              output logic [5:0] ev_vec, output bit expired);
        logic [5:0] cur;
        expired = 1'b1;
        ev_cyc  = cyc;
        ev_vec  = sel_b ? vec_b : vec_a;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cur = sel_b ? vec_b : vec_a;
            if (cur !== (sel_b ? prev_b : prev_a)) begin
                if (sel_b) prev_b = cur;
                else       prev_a = cur;
                ev_cyc  = cyc;
                ev_vec  = cur;
                expired = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset(output int base);
        @(negedge clk);
        rst = 1'b1;
        ifa.pll_locked = 1'b0; ifa.restart = 1'b0;
        ifb.pll_locked = 1'b0; ifb.restart = 1'b0;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        base   = cyc;
        prev_a = vec_a;
        prev_b = vec_b;
    endtask

    task automatic test_reset();
        int b;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (vec_a !== mk(0, 0, 0, 0, 1)) begin
            tests_failed++;
            $display("FAIL reset_a: out=%b required %b", vec_a, mk(0, 0, 0, 0, 1));
        end
        tests_run++;
        if (vec_b !== mk(0, 0, 0, 0, 1)) begin
            tests_failed++;
            $display("FAIL reset_b: out=%b required %b", vec_b, mk(0, 0, 0, 0, 1));
        end
        do_reset(b);
        @(negedge clk);
        tests_run++;
        if (vec_a !== mk(0, 0, 0, 0, 1)) begin
            tests_failed++;
            $display("FAIL reset_release_a: out=%b required %b", vec_a, mk(0, 0, 0, 0, 1));
        end
        tests_run++;
        if (vec_b !== mk(0, 0, 0, 0, 1)) begin
            tests_failed++;
            $display("FAIL reset_release_b: out=%b required %b", vec_b, mk(0, 0, 0, 0, 1));
        end
        $display("[TB] reset: a=%b b=%b", vec_a, vec_b);
    endtask

    task automatic test_normal_lock();
        int b, n, oc; logic [5:0] ov; bit to; exp_t e;
        do_reset(b);
        // pll_rst high for exactly 16 cycles after release
        exp_q.push_back('{cyc: b + 16, vec: mk(0, 0, 0, 0, 0)});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_event(1'b0, 5000, oc, ov, to);
            tests_run++;
            if (to || oc != e.cyc || ov !== e.vec) begin
                tests_failed++;
                $display("FAIL normal_lock: got +%0d out=%b, required +%0d out=%b", oc - b, ov, e.cyc - b, e.vec);
            end else $display("[TB] normal_lock: +%0d out=%b", oc - b, ov);
        end
        repeat (5) @(negedge clk);
        ifa.pll_locked = 1'b1;
        n = cyc;
        // 2 sync + 1 WAIT->STABLE + 64 stable cycles
        exp_q.push_back('{cyc: n + 67, vec: mk(0, 0, 0, 1, 0)});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_event(1'b0, 5000, oc, ov, to);
            tests_run++;
            if (to || oc != e.cyc || ov !== e.vec) begin
                tests_failed++;
                $display("FAIL normal_ready: got +%0d out=%b, required +%0d out=%b", oc - n, ov, e.cyc - n, e.vec);
            end else $display("[TB] normal_ready: +%0d out=%b", oc - n, ov);
        end
    endtask

    task automatic test_lock_loss();
        int n, oc; logic [5:0] ov; bit to; exp_t e;
        repeat (3) @(negedge clk);
        ifa.pll_locked = 1'b0;
        n = cyc;
        // lk falls 2 edges later; the registered pulse appears on the next edge
        exp_q.push_back('{cyc: n + 3,  vec: mk(0, 1, 0, 0, 1)});
        exp_q.push_back('{cyc: n + 4,  vec: mk(0, 0, 0, 0, 1)});
        exp_q.push_back('{cyc: n + 19, vec: mk(0, 0, 0, 0, 0)});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_event(1'b0, 5000, oc, ov, to);
            tests_run++;
            if (to || oc != e.cyc || ov !== e.vec) begin
                tests_failed++;
                $display("FAIL lock_loss: got +%0d out=%b, required +%0d out=%b", oc - n, ov, e.cyc - n, e.vec);
            end else $display("[TB] lock_loss: +%0d out=%b", oc - n, ov);
        end
    endtask

    task automatic test_async_reset();
        int n, oc; logic [5:0] ov; bit to; exp_t e;
        ifa.pll_locked = 1'b1;
        n = cyc;
        exp_q.push_back('{cyc: n + 67, vec: mk(0, 0, 0, 1, 0)});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_event(1'b0, 5000, oc, ov, to);
            tests_run++;
            if (to || oc != e.cyc || ov !== e.vec) begin
                tests_failed++;
                $display("FAIL async_relock: got +%0d out=%b, required +%0d out=%b", oc - n, ov, e.cyc - n, e.vec);
            end else $display("[TB] async_relock: +%0d out=%b", oc - n, ov);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (vec_a !== mk(0, 0, 0, 0, 1)) begin
            tests_failed++;
            $display("FAIL async_reset: out=%b required %b before next edge", vec_a, mk(0, 0, 0, 0, 1));
        end else $display("[TB] async_reset: out=%b", vec_a);
        ifa.pll_locked = 1'b0;
    endtask

    task automatic test_timeout_retry();
        int b, oc; logic [5:0] ov; bit to; exp_t e;
        do_reset(b);
        exp_q.push_back('{cyc: b + 16,  vec: mk(0, 0, 0, 0, 0)});
        exp_q.push_back('{cyc: b + 116, vec: mk(1, 0, 0, 0, 1)});
        exp_q.push_back('{cyc: b + 132, vec: mk(1, 0, 0, 0, 0)});
        exp_q.push_back('{cyc: b + 232, vec: mk(2, 0, 0, 0, 1)});
        exp_q.push_back('{cyc: b + 248, vec: mk(2, 0, 0, 0, 0)});
        exp_q.push_back('{cyc: b + 348, vec: mk(2, 0, 1, 0, 1)});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_event(1'b1, 5000, oc, ov, to);
            tests_run++;
            if (to || oc != e.cyc || ov !== e.vec) begin
                tests_failed++;
                $display("FAIL timeout_retry: got +%0d out=%b, required +%0d out=%b", oc - b, ov, e.cyc - b, e.vec);
            end else $display("[TB] timeout_retry: +%0d out=%b", oc - b, ov);
        end
        next_event(1'b1, 1000, oc, ov, to);
        tests_run++;
        if (!to) begin
            tests_failed++;
            $display("FAIL fail_hold: out changed to %b at +%0d, required no change", ov, oc - b);
        end
        tests_run++;
        if (vec_b !== mk(2, 0, 1, 0, 1)) begin
            tests_failed++;
            $display("FAIL fail_state: out=%b required %b", vec_b, mk(2, 0, 1, 0, 1));
        end else $display("[TB] fail_hold: out=%b", vec_b);
    endtask

    task automatic test_restart_from_fail();
        int n, m, oc; logic [5:0] ov; bit to; exp_t e;
        @(negedge clk);
        ifb.restart = 1'b1;
        n = cyc;
        exp_q.push_back('{cyc: n + 1, vec: mk(0, 0, 0, 0, 1)});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_event(1'b1, 50, oc, ov, to);
            tests_run++;
            if (to || oc != e.cyc || ov !== e.vec) begin
                tests_failed++;
                $display("FAIL restart_fail: got +%0d out=%b, required +%0d out=%b", oc - n, ov, e.cyc - n, e.vec);
            end else $display("[TB] restart_fail: +%0d out=%b", oc - n, ov);
        end
        ifb.restart = 1'b0;
        exp_q.push_back('{cyc: n + 17, vec: mk(0, 0, 0, 0, 0)});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_event(1'b1, 5000, oc, ov, to);
            tests_run++;
            if (to || oc != e.cyc || ov !== e.vec) begin
                tests_failed++;
                $display("FAIL restart_hold: got +%0d out=%b, required +%0d out=%b", oc - n, ov, e.cyc - n, e.vec);
            end else $display("[TB] restart_hold: +%0d out=%b", oc - n, ov);
        end
        ifb.pll_locked = 1'b1;
        m = cyc;
        exp_q.push_back('{cyc: m + 11, vec: mk(0, 0, 0, 1, 0)});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_event(1'b1, 5000, oc, ov, to);
            tests_run++;
            if (to || oc != e.cyc || ov !== e.vec) begin
                tests_failed++;
                $display("FAIL restart_ready: got +%0d out=%b, required +%0d out=%b", oc - m, ov, e.cyc - m, e.vec);
            end else $display("[TB] restart_ready: +%0d out=%b", oc - m, ov);
        end
    endtask

    task automatic test_glitch_stable();
        int b, n, oc; logic [5:0] ov; bit to; exp_t e;
        do_reset(b);
        exp_q.push_back('{cyc: b + 16, vec: mk(0, 0, 0, 0, 0)});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_event(1'b1, 5000, oc, ov, to);
            tests_run++;
            if (to || oc != e.cyc || ov !== e.vec) begin
                tests_failed++;
                $display("FAIL glitch_hold: got +%0d out=%b, required +%0d out=%b", oc - b, ov, e.cyc - b, e.vec);
            end
        end
        ifb.pll_locked = 1'b1;
        // STABLE is entered 3 edges later; drop the lock while cnt==5
        repeat (8) @(negedge clk);
        ifb.pll_locked = 1'b0;
        @(negedge clk);
        ifb.pll_locked = 1'b1;
        n = cyc;
        exp_q.push_back('{cyc: n + 11, vec: mk(0, 0, 0, 1, 0)});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_event(1'b1, 5000, oc, ov, to);
            tests_run++;
            if (to || oc != e.cyc || ov !== e.vec) begin
                tests_failed++;
                $display("FAIL glitch_ready: got +%0d out=%b, required +%0d out=%b", oc - n, ov, e.cyc - n, e.vec);
            end else $display("[TB] glitch_ready: +%0d out=%b", oc - n, ov);
        end
    endtask

    task automatic test_restart_timeout();
        int b, oc; logic [5:0] ov; bit to; exp_t e;
        do_reset(b);
        exp_q.push_back('{cyc: b + 16,  vec: mk(0, 0, 0, 0, 0)});
        exp_q.push_back('{cyc: b + 116, vec: mk(1, 0, 0, 0, 1)});
        exp_q.push_back('{cyc: b + 132, vec: mk(1, 0, 0, 0, 0)});
        exp_q.push_back('{cyc: b + 232, vec: mk(2, 0, 0, 0, 1)});
        exp_q.push_back('{cyc: b + 248, vec: mk(2, 0, 0, 0, 0)});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_event(1'b1, 5000, oc, ov, to);
            tests_run++;
            if (to || oc != e.cyc || ov !== e.vec) begin
                tests_failed++;
                $display("FAIL rt_attempts: got +%0d out=%b, required +%0d out=%b", oc - b, ov, e.cyc - b, e.vec);
            end
        end
        // restart high on the very edge where the final timeout would hit
        if (cyc < b + 347) repeat (b + 347 - cyc) @(negedge clk);
        ifb.restart = 1'b1;
        exp_q.push_back('{cyc: b + 348, vec: mk(0, 0, 0, 0, 1)});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_event(1'b1, 50, oc, ov, to);
            tests_run++;
            if (to || oc != e.cyc || ov !== e.vec) begin
                tests_failed++;
                $display("FAIL restart_vs_timeout: got +%0d out=%b, required +%0d out=%b", oc - b, ov, e.cyc - b, e.vec);
            end else $display("[TB] restart_vs_timeout: +%0d out=%b", oc - b, ov);
        end
        ifb.restart = 1'b0;
        exp_q.push_back('{cyc: b + 364, vec: mk(0, 0, 0, 0, 0)});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            next_event(1'b1, 5000, oc, ov, to);
            tests_run++;
            if (to || oc != e.cyc || ov !== e.vec) begin
                tests_failed++;
                $display("FAIL rt_rehold: got +%0d out=%b, required +%0d out=%b", oc - b, ov, e.cyc - b, e.vec);
            end else $display("[TB] rt_rehold: +%0d out=%b", oc - b, ov);
        end
    endtask

    initial begin
        ifa.pll_locked = 1'b0; ifa.restart = 1'b0;
        ifb.pll_locked = 1'b0; ifb.restart = 1'b0;
        prev_a = '0;
        prev_b = '0;
        test_reset();
        test_normal_lock();
        test_lock_loss();
        test_async_reset();
        test_timeout_retry();
        test_restart_from_fail();
        test_glitch_stable();
        test_restart_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
